serializer_pipe: RTL and testbench

SERIALIZER_PIPE -- requirements
Module: serializer_pipe

---
 rtl/serializer_pkg.sv | 15 +
 rtl/serializer_parity.sv | 12 +
 rtl/serializer_pipe.sv | 121 ++++++++++++
 tb/tb_serializer_pipe.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/serializer_pkg.sv
// Shared definitions for the parallel-to-serial frame shifter.
package serializer_pkg;

  localparam int unsigned DefDataW     = 8;
  localparam int unsigned DefMsbFirst  = 0;
  localparam int unsigned DefParityEn  = 0;
  localparam int unsigned DefParityOdd = 0;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShift  = 2'd1,
    StParity = 2'd2
  } state_e;

endpackage

// File: rtl/serializer_parity.sv
// Combinational parity of a parallel word; odd select inverts the even result.
module serializer_parity #(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_word,
  input  logic              i_odd,
  output logic              o_parity
);

  assign o_parity = (^i_word) ^ i_odd;

endmodule

// File: rtl/serializer_pipe.sv
// Loads a parallel word and shifts it out one bit per cycle, with optional trailing parity bit.
module serializer_pipe
  import serializer_pkg::*;
#(
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned MSB_FIRST  = DefMsbFirst,
  parameter int unsigned PARITY_EN  = DefParityEn,
  parameter int unsigned PARITY_ODD = DefParityOdd
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] par_input,
  input  logic              store,
  output logic              ready,
  output logic              ser_output,
  output logic              ser_valid,
  output logic              ser_last,
  output logic              empty
);

  localparam int unsigned     FrameLen = DATA_W + PARITY_EN;
  localparam int unsigned     CntW     = $clog2(FrameLen + 1);
  localparam logic [CntW-1:0] CntLoad  = CntW'(FrameLen);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [CntW-1:0] CntTwo   = CntW'(2);

  state_e            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_shift, w_shift_nxt;
  logic [CntW-1:0]   r_cnt, w_cnt_nxt;
  logic              r_par, w_par_nxt;
  logic              r_out, w_out_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_last, w_last_nxt;
  logic              w_parity;
  logic              w_end;
  logic              w_accept;

  serializer_parity #(
    .DATA_W (DATA_W)
  ) u_parity (
    .i_word   (par_input),
    .i_odd    (PARITY_ODD != 0),
    .o_parity (w_parity)
  );

  assign w_end      = r_valid & r_last;
  assign ready      = (r_state == StIdle) | w_end;
  assign w_accept   = store & ready;
  assign empty      = (r_state == StIdle);
  assign ser_output = r_out;
  assign ser_valid  = r_valid;
  assign ser_last   = r_last;

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_par_nxt   = r_par;
    w_out_nxt   = r_out;
    w_valid_nxt = r_valid;
    w_last_nxt  = r_last;

    if (w_accept) begin
      // First bit goes straight to the output register; the rest wait in r_shift.
      w_state_nxt = StShift;
      w_cnt_nxt   = CntLoad;
      w_par_nxt   = (PARITY_EN != 0) ? w_parity : 1'b0;
      w_valid_nxt = 1'b1;
      w_last_nxt  = 1'b0;
      if (MSB_FIRST != 0) begin
        w_out_nxt   = par_input[DATA_W-1];
        w_shift_nxt = par_input << 1;
      end else begin
        w_out_nxt   = par_input[0];
        w_shift_nxt = par_input >> 1;
      end
    end else if ((r_state == StIdle) || w_end) begin
      w_state_nxt = StIdle;
      w_cnt_nxt   = '0;
      w_shift_nxt = '0;
      w_out_nxt   = 1'b0;
      w_valid_nxt = 1'b0;
      w_last_nxt  = 1'b0;
    end else begin
      // r_cnt counts bits still to show, including the one on the output now.
      w_cnt_nxt  = r_cnt - CntOne;
      w_last_nxt = (r_cnt == CntTwo);
      if ((PARITY_EN != 0) && (r_cnt == CntTwo)) begin
        w_state_nxt = StParity;
        w_out_nxt   = r_par;
      end else if (MSB_FIRST != 0) begin
        w_out_nxt   = r_shift[DATA_W-1];
        w_shift_nxt = r_shift << 1;
      end else begin
        w_out_nxt   = r_shift[0];
        w_shift_nxt = r_shift >> 1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_shift <= '0;
      r_cnt   <= '0;
      r_par   <= 1'b0;
      r_out   <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_par   <= w_par_nxt;
      r_out   <= w_out_nxt;
      r_valid <= w_valid_nxt;
      r_last  <= w_last_nxt;
    end
  end

endmodule

// File: tb/tb_serializer_pipe.sv
// Scoreboard bench: four serializer configurations, expected frames queued at load time.
module tb_serializer_pipe;

  typedef struct {
    int   k;
    logic b;
    logic l;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] store;
  logic [7:0] par [4];
  logic [3:0] ready, ser, valid, last, empty;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   run_len = 0;
  int   max_run = 0;
  int   last_cnt = 0;

  always #5 clk = ~clk;

  // 0: LSB first, 1: MSB first, 2: even parity, 3: odd parity
  serializer_pipe #(.DATA_W(8), .MSB_FIRST(0), .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (
    .clock(clk), .reset_n(reset_n), .par_input(par[0]), .store(store[0]), .ready(ready[0]),
    .ser_output(ser[0]), .ser_valid(valid[0]), .ser_last(last[0]), .empty(empty[0])
  );
  serializer_pipe #(.DATA_W(8), .MSB_FIRST(1), .PARITY_EN(0), .PARITY_ODD(0)) u_dut1 (
    .clock(clk), .reset_n(reset_n), .par_input(par[1]), .store(store[1]), .ready(ready[1]),
    .ser_output(ser[1]), .ser_valid(valid[1]), .ser_last(last[1]), .empty(empty[1])
  );
  serializer_pipe #(.DATA_W(8), .MSB_FIRST(0), .PARITY_EN(1), .PARITY_ODD(0)) u_dut2 (
    .clock(clk), .reset_n(reset_n), .par_input(par[2]), .store(store[2]), .ready(ready[2]),
    .ser_output(ser[2]), .ser_valid(valid[2]), .ser_last(last[2]), .empty(empty[2])
  );
  serializer_pipe #(.DATA_W(8), .MSB_FIRST(0), .PARITY_EN(1), .PARITY_ODD(1)) u_dut3 (
    .clock(clk), .reset_n(reset_n), .par_input(par[3]), .store(store[3]), .ready(ready[3]),
    .ser_output(ser[3]), .ser_valid(valid[3]), .ser_last(last[3]), .empty(empty[3])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // bits[j] is the j-th bit expected on the wire.
  task automatic load(input int k, input logic [7:0] w, input logic [8:0] bits, input int len);
    bit done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      store[k] = 1'b1;
      par[k]   = w;
      if (ready[k]) begin
        for (int j = 0; j < len; j++) exp_q.push_back('{k, bits[j], (j == len - 1)});
        @(posedge clk);
        #1;
        store[k] = 1'b0;
        chk($sformatf("latency1_valid_inst%0d", k), {31'd0, valid[k]}, 32'd1);
        done = 1'b1;
      end
    end
    if (!done) begin
      store[k] = 1'b0;
      chk($sformatf("load_timeout_ready_inst%0d", k), {31'd0, ready[k]}, 32'd1);
    end
  endtask

  task automatic wait_idle(input int k, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (empty[k]) seen = 1'b1;
    end
    chk({name, "_idle_outs"}, {28'd0, empty[k], ready[k], valid[k], ser[k]}, 32'b1100);
    chk({name, "_drained"}, exp_q.size(), 32'd0);
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (valid[k] === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("unexpected_bit_inst%0d", k), {31'd0, valid[k]}, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.k != k)
            chk($sformatf("wrong_inst_emitting_%0d", k), {31'd0, valid[k]}, 32'd0);
          else
            chk($sformatf("ser_bit_last_inst%0d", k), {30'd0, ser[k], last[k]},
                {30'd0, mon_e.b, mon_e.l});
        end
      end
    end
    if (valid[0] === 1'b1) begin
      run_len++;
      if (last[0] === 1'b1) last_cnt++;
    end else begin
      if (run_len > max_run) max_run = run_len;
      run_len = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    reset_n = 1'b0;
    store   = '0;
    for (int k = 0; k < 4; k++) par[k] = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {12'd0, ser, valid, last, empty, ready}, {12'd0, 20'h000FF});
    reset_n = 1'b1;

    load(0, 8'hA5, 9'h0A5, 8);
    wait_idle(0, "lsb_a5");

    load(1, 8'hA5, 9'h0A5, 8);
    wait_idle(1, "msb_a5");
    load(1, 8'h01, 9'h080, 8);
    wait_idle(1, "msb_01");

    load(2, 8'h07, 9'h107, 9);
    wait_idle(2, "even_07");
    load(3, 8'h07, 9'h007, 9);
    wait_idle(3, "odd_07");
    load(2, 8'hA5, 9'h0A5, 9);
    wait_idle(2, "even_a5");
    load(3, 8'hA5, 9'h1A5, 9);
    wait_idle(3, "odd_a5");

    @(negedge clk);
    run_len  = 0;
    max_run  = 0;
    last_cnt = 0;
    load(0, 8'hFF, 9'h0FF, 8);
    load(0, 8'h00, 9'h000, 8);
    wait_idle(0, "b2b");
    @(negedge clk);
    chk("b2b_valid_run", max_run, 32'd16);
    chk("b2b_last_pulses", last_cnt, 32'd2);

    load(2, 8'h07, 9'h107, 9);
    load(2, 8'hA5, 9'h0A5, 9);
    wait_idle(2, "b2b_parity");

    load(0, 8'hA5, 9'h0A5, 8);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("ready_mid_frame", {31'd0, ready[0]}, 32'd0);
    store[0] = 1'b1;
    par[0]   = 8'h3C;
    @(posedge clk);
    #1;
    store[0] = 1'b0;
    wait_idle(0, "store_ignored");

    load(0, 8'hA5, 9'h0A5, 8);
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("reset_mid_frame", {27'd0, ser[0], valid[0], last[0], empty[0], ready[0]}, 32'b00011);
    repeat (2) @(negedge clk);
    chk("reset_held", {27'd0, ser[0], valid[0], last[0], empty[0], ready[0]}, 32'b00011);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    load(0, 8'h81, 9'h081, 8);
    wait_idle(0, "after_reset_81");

    repeat (2) @(negedge clk);
    chk("queue_empty_end", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
